// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller.
// Latches a button press, waits for the vehicle light to enter red, then runs
// a WALK phase followed by a flashing-clear phase. Any non-red light sampled
// during the crossing aborts it back to IDLE.
// Optional feature: define PED_COUNTDOWN_EN to expose the 4-bit countdown port.
//
// state  | meaning
// IDLE   | no request, dont_walk lit
// ARMED  | press latched, waiting for red entry
// WALK   | walk lit for WALK_TIME cycles
// CLEAR  | dont_walk flashing for CLEAR_TIME cycles
module ped_crossing_ctrl #(
    parameter int WALK_TIME  = 4,
    parameter int CLEAR_TIME = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] light,
    input  logic       ped_btn,
    output logic       walk,
    output logic       dont_walk,
    output logic       req_pending
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [3:0] countdown
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_WALK  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [3:0] WALK_LAST  = 4'(WALK_TIME - 1);
    localparam logic [3:0] CLEAR_LAST = 4'(CLEAR_TIME - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic [1:0] light_prev_q, light_prev_d;
    logic       btn_prev_q, btn_prev_d;
    logic       walk_q, walk_d;
    logic       dont_walk_q, dont_walk_d;
    logic       req_pending_q, req_pending_d;

    logic is_red;
    logic red_entry;
    logic press;

    assign is_red    = (light == 2'b00);
    // Code 11 is treated as non-red, so 11->00 is a valid red entry.
    assign red_entry = is_red && (light_prev_q != 2'b00);
    assign press     = ped_btn && !btn_prev_q;

    // Next-state decision; abort on non-red takes priority over phase expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (press && red_entry) state_d = ST_WALK;
                else if (press)         state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (red_entry) state_d = ST_WALK;
            end
            ST_WALK: begin
                if (!is_red)                   state_d = ST_IDLE;
                else if (timer_q == WALK_LAST) state_d = ST_WALK == ST_WALK ? ST_CLEAR : ST_IDLE;
            end
            ST_CLEAR: begin
                if (!is_red)                    state_d = ST_IDLE;
                else if (timer_q == CLEAR_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase timer and registered outputs, all derived from the next state.
    always_comb begin
        if ((state_d != state_q) || (state_d == ST_IDLE) || (state_d == ST_ARMED))
            timer_d = 4'd0;
        else
            timer_d = timer_q + 4'd1;

        walk_d        = (state_d == ST_WALK);
        // First CLEAR cycle has timer 0, so dont_walk starts at 1 and alternates.
        dont_walk_d   = (state_d == ST_CLEAR) ? ~timer_d[0] : (state_d != ST_WALK);
        req_pending_d = (state_d == ST_ARMED);
        light_prev_d  = light;
        btn_prev_d    = ped_btn;
    end

    // Core state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= 4'd0;
            light_prev_q  <= 2'b00;
            btn_prev_q    <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            req_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            light_prev_q  <= light_prev_d;
            btn_prev_q    <= btn_prev_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
            req_pending_q <= req_pending_d;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dont_walk_q;
    assign req_pending = req_pending_q;

`ifdef PED_COUNTDOWN_EN
    localparam logic [3:0] CD_LOAD = 4'(WALK_TIME + CLEAR_TIME - 1);

    logic [3:0] countdown_q, countdown_d;

    // Remaining crossing cycles: load on WALK entry, count down, zero elsewhere.
    always_comb begin
        if ((state_d == ST_WALK) && (state_q != ST_WALK))
            countdown_d = CD_LOAD;
        else if (((state_d == ST_WALK) || (state_d == ST_CLEAR)) && (countdown_q != 4'd0))
            countdown_d = countdown_q - 4'd1;
        else
            countdown_d = 4'd0;
    end

    // Countdown register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) countdown_q <= 4'd0;
        else       countdown_q <= countdown_d;
    end

    assign countdown = countdown_q;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed testbench for ped_crossing_ctrl with WALK_TIME=4, CLEAR_TIME=3.
// Outputs are sampled 1 time unit after the rising edge.
module tb_ped_crossing_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] light;
    logic       ped_btn;
    logic       walk;
    logic       dont_walk;
    logic       req_pending;
`ifdef PED_COUNTDOWN_EN
    logic [3:0] countdown;
`endif

    int vectors;
    int miscompares;

    ped_crossing_ctrl #(.WALK_TIME(4), .CLEAR_TIME(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .light       (light),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .req_pending (req_pending)
`ifdef PED_COUNTDOWN_EN
        ,
        .countdown   (countdown)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        reset   = 1'b1;
        light   = 2'b00;
        ped_btn = 1'b0;
        tick();
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b expected=010", obs);
        end
`ifdef PED_COUNTDOWN_EN
        vectors++;
        if (countdown !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_countdown got=%0d expected=0", countdown);
        end
`endif
        reset = 1'b0;
        light = 2'b01;
        tick();
    endtask

    task automatic test_normal_crossing();
        logic [2:0] obs;
        logic [2:0] exp_o  [8] = '{3'b100, 3'b100, 3'b100, 3'b100,
                                   3'b010, 3'b000, 3'b010, 3'b010};
        logic [3:0] exp_cd [8] = '{4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd0};
        ped_btn = 1'b1;
        tick();
        ped_btn = 1'b0;
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b011) begin
            miscompares++;
            $display("FAIL normal_armed got=%b expected=011", obs);
        end
        light = 2'b10;
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b011) begin
            miscompares++;
            $display("FAIL normal_armed_yellow got=%b expected=011", obs);
        end
        light = 2'b00;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {walk, dont_walk, req_pending};
            vectors++;
            if (obs !== exp_o[i]) begin
                miscompares++;
                $display("FAIL normal_phase[%0d] got=%b expected=%b", i, obs, exp_o[i]);
            end
`ifdef PED_COUNTDOWN_EN
            vectors++;
            if (countdown !== exp_cd[i]) begin
                miscompares++;
                $display("FAIL normal_countdown[%0d] got=%0d expected=%0d", i, countdown, exp_cd[i]);
            end
`endif
            // A press during WALK must be ignored (req_pending stays 0 afterwards).
            if (i == 1) ped_btn = 1'b1;
            if (i == 2) ped_btn = 1'b0;
        end
    endtask

    task automatic test_abort();
        logic [2:0] obs;
        light   = 2'b01;
        ped_btn = 1'b1;
        tick();
        ped_btn = 1'b0;
        light   = 2'b00;
        tick();
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b100) begin
            miscompares++;
            $display("FAIL abort_walk2 got=%b expected=100", obs);
        end
        light = 2'b01;
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++;
            $display("FAIL abort_idle got=%b expected=010", obs);
        end
`ifdef PED_COUNTDOWN_EN
        vectors++;
        if (countdown !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_countdown got=%0d expected=0", countdown);
        end
`endif
    endtask

    task automatic test_same_edge();
        logic [2:0] obs;
        light = 2'b11;
        tick();
        light   = 2'b00;
        ped_btn = 1'b1;
        tick();
        ped_btn = 1'b0;
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b100) begin
            miscompares++;
            $display("FAIL same_edge_walk got=%b expected=100", obs);
        end
        light = 2'b10;
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++;
            $display("FAIL same_edge_abort got=%b expected=010", obs);
        end
    endtask

    task automatic test_press_while_red();
        logic [2:0] obs;
        light = 2'b00;
        tick();
        tick();
        ped_btn = 1'b1;
        tick();
        ped_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = {walk, dont_walk, req_pending};
            vectors++;
            if (obs !== 3'b011) begin
                miscompares++;
                $display("FAIL red_press_armed[%0d] got=%b expected=011", i, obs);
            end
            tick();
        end
        light = 2'b01;
        tick();
        light = 2'b00;
        tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b100) begin
            miscompares++;
            $display("FAIL red_press_walk got=%b expected=100", obs);
        end
    endtask

    task automatic test_reset_in_clear();
        logic [2:0] obs;
        for (int i = 0; i < 5; i++) tick();
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b000) begin
            miscompares++;
            $display("FAIL clear_before_reset got=%b expected=000", obs);
        end
        #2;
        reset = 1'b1;
        #1;
        obs = {walk, dont_walk, req_pending};
        vectors++;
        if (obs !== 3'b010) begin
            miscompares++;
            $display("FAIL async_reset got=%b expected=010", obs);
        end
`ifdef PED_COUNTDOWN_EN
        vectors++;
        if (countdown !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset_countdown got=%0d expected=0", countdown);
        end
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        // Light held red across reset: a press here must only arm.
        ped_btn = 1'b1;
        tick();
        ped_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            obs = {walk, dont_walk, req_pending};
            vectors++;
            if (obs !== 3'b011) begin
                miscompares++;
                $display("FAIL post_reset_no_walk[%0d] got=%b expected=011", i, obs);
            end
            tick();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_normal_crossing();
        test_abort();
        test_same_edge();
        test_press_while_red();
        test_reset_in_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
